// File: rtl/d_stream_gen.sv
`default_nettype none
// ============================================================================
// d_stream_gen : valid/ready token source emitting start + k*stride, k < count
// Rev 1.0 - initial release
// ============================================================================
module d_stream_gen #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  cfg_start,
  input  logic [DATA_WIDTH-1:0]  cfg_stride,
  input  logic [COUNT_WIDTH-1:0] cfg_count,
  input  logic                   go,
  input  logic                   dout_r,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_v,
  output logic                   dout_last,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] c_cnt_one  = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] c_cnt_zero = '0;

  state_t                 state_q,  state_d;
  logic [DATA_WIDTH-1:0]  dout_q,   dout_d;
  logic [DATA_WIDTH-1:0]  stride_q, stride_d;
  logic [COUNT_WIDTH-1:0] count_q,  count_d;
  logic [COUNT_WIDTH-1:0] index_q,  index_d;
  logic                   dout_v_q, dout_v_d;
  logic                   done_q,   done_d;

  logic is_last;
  logic xfer;

  // count_q is nonzero whenever dout_v_q is set, so the subtraction never wraps
  // in a case that is observed.
  assign is_last = (index_q == (count_q - c_cnt_one));
  assign xfer    = dout_v_q & dout_r;

  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    stride_d = stride_q;
    count_d  = count_q;
    index_d  = index_q;
    dout_v_d = dout_v_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          if (cfg_count != c_cnt_zero) begin
            stride_d = cfg_stride;
            count_d  = cfg_count;
            dout_d   = cfg_start;
            index_d  = c_cnt_zero;
            dout_v_d = 1'b1;
            state_d  = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (xfer) begin
          if (is_last) begin
            dout_v_d = 1'b0;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            dout_d  = dout_q + stride_q;
            index_d = index_q + c_cnt_one;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      dout_q   <= '0;
      stride_q <= '0;
      count_q  <= '0;
      index_q  <= '0;
      dout_v_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dout_q   <= dout_d;
      stride_q <= stride_d;
      count_q  <= count_d;
      index_q  <= index_d;
      dout_v_q <= dout_v_d;
      done_q   <= done_d;
    end
  end

  assign dout      = dout_q;
  assign dout_v    = dout_v_q;
  assign dout_last = dout_v_q & is_last;
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;

endmodule
`default_nettype wire
